// File: rtl/mem_handshake_responder.sv
// Memory-side responder for the CPU MOV/MOC handshake: a 2^ADDR_BITS-byte big-endian
// store with a programmable number of wait states before MOC is raised.
module mem_handshake_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BITS   = 8
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  typeData,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        MERR
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LAST  = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic        req_rw;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_data;

  logic [7:0] mem [DEPTH];

  logic        src_rw;
  logic [1:0]  src_size;
  logic [31:0] src_addr;
  logic [31:0] src_data;

  logic [ADDR_BITS-1:0] idx0, idx1, idx2, idx3;
  logic [31:0] rdata_c;
  logic        err_c;

  logic        capture_c;
  logic        access_c;
  logic        wr_en_c;
  logic        moc_next;
  logic        merr_next;
  logic [31:0] dout_next;

  // With no wait states the access happens on the capture edge, so use live inputs in IDLE.
  always_comb begin
    src_rw   = req_rw;
    src_size = req_size;
    src_addr = req_addr;
    src_data = req_data;
    if (state == IDLE) begin
      src_rw   = RW;
      src_size = typeData;
      src_addr = Address;
      src_data = DataIn;
    end
  end

  // Byte lanes of the addressed location, most significant byte at the lowest address.
  always_comb begin
    idx0 = src_addr[ADDR_BITS-1:0];
    idx1 = idx0 + ADDR_BITS'(1);
    idx2 = idx0 + ADDR_BITS'(2);
    idx3 = idx0 + ADDR_BITS'(3);

    err_c = 1'b0;
    if ((src_addr >> ADDR_BITS) != 32'd0) err_c = 1'b1;
    case (src_size)
      SZ_BYTE: ;
      SZ_HALF: if (src_addr[0]) err_c = 1'b1;
      SZ_WORD: if (src_addr[1:0] != 2'b00) err_c = 1'b1;
      default: err_c = 1'b1;
    endcase

    case (src_size)
      SZ_BYTE: rdata_c = {24'h0, mem[idx0]};
      SZ_HALF: rdata_c = {16'h0, mem[idx0], mem[idx1]};
      default: rdata_c = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
    endcase
  end

  // Handshake FSM: next state, counter and registered-output next values.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture_c  = 1'b0;
    access_c   = 1'b0;
    moc_next   = MOC;
    merr_next  = MERR;
    dout_next  = DataOut;

    case (state)
      IDLE: begin
        if (MOV) begin
          capture_c = 1'b1;
          cnt_next  = '0;
          if (WAIT_CYCLES == 0) begin
            access_c   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt + CNT_W'(1);
        if (!MOV) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(LAST)) begin
          access_c   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (MOV) begin
          moc_next = 1'b1;
        end else begin
          state_next = IDLE;
          moc_next   = 1'b0;
          merr_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        moc_next   = 1'b0;
        merr_next  = 1'b0;
      end
    endcase

    if (access_c) begin
      merr_next = err_c;
      if (err_c) begin
        dout_next = '0;
      end else if (src_rw) begin
        dout_next = rdata_c;
      end
    end
  end

  // Gate on CLR so a write can never commit while reset is held.
  assign wr_en_c = access_c && !err_c && !src_rw && !CLR;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      cnt      <= '0;
      MOC      <= 1'b0;
      MERR     <= 1'b0;
      DataOut  <= '0;
      req_rw   <= 1'b0;
      req_size <= 2'b00;
      req_addr <= '0;
      req_data <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      MOC     <= moc_next;
      MERR    <= merr_next;
      DataOut <= dout_next;
      if (capture_c) begin
        req_rw   <= RW;
        req_size <= typeData;
        req_addr <= Address;
        req_data <= DataIn;
      end
    end
  end

  // Storage array is deliberately not reset; contents survive CLR.
  always_ff @(posedge CLK) begin
    if (wr_en_c) begin
      case (src_size)
        SZ_BYTE: mem[idx0] <= src_data[7:0];
        SZ_HALF: begin
          mem[idx0] <= src_data[15:8];
          mem[idx1] <= src_data[7:0];
        end
        default: begin
          mem[idx0] <= src_data[31:24];
          mem[idx1] <= src_data[23:16];
          mem[idx2] <= src_data[15:8];
          mem[idx3] <= src_data[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_handshake_responder.sv
// Scoreboard bench for mem_handshake_responder: random and directed handshakes checked
// against a byte-array reference model; a second instance covers zero wait states.
module tb_mem_handshake_responder;

  localparam int unsigned WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        mov = 1'b0, rw = 1'b0;
  logic [1:0]  tdata = 2'b00;
  logic [31:0] addr = '0, din = '0;
  logic [31:0] dout;
  logic        moc, merr;

  logic        mov0 = 1'b0, rw0 = 1'b0;
  logic [1:0]  tdata0 = 2'b00;
  logic [31:0] addr0 = '0, din0 = '0;
  logic [31:0] dout0;
  logic        moc0, merr0;

  always #5 clk = ~clk;

  mem_handshake_responder #(.WAIT_CYCLES(WAIT), .ADDR_BITS(8)) dut (
    .CLK(clk), .CLR(rst), .MOV(mov), .RW(rw), .typeData(tdata), .Address(addr),
    .DataIn(din), .DataOut(dout), .MOC(moc), .MERR(merr)
  );

  mem_handshake_responder #(.WAIT_CYCLES(0), .ADDR_BITS(8)) dut0 (
    .CLK(clk), .CLR(rst), .MOV(mov0), .RW(rw0), .typeData(tdata0), .Address(addr0),
    .DataIn(din0), .DataOut(dout0), .MOC(moc0), .MERR(merr0)
  );

  typedef struct {
    logic        merr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_dout = '0;
  logic        moc_prev = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: apply the access to the byte array and queue the expected completion.
  task automatic model_access(input logic r, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d);
    int nb;
    logic bad;
    logic [31:0] v;
    exp_t e;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad = (a > 32'd255) || (sz == 2'b11) || ((a % 32'(nb)) != 0);
    if (bad) begin
      exp_dout = '0;
    end else if (r) begin
      v = '0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[a[7:0] + 8'(i)]);
      exp_dout = v;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[a[7:0] + 8'(i)] = 8'(d >> (8 * (nb - 1 - i)));
    end
    e.merr = bad;
    e.data = exp_dout;
    sb_q.push_back(e);
  endtask

  // Monitor: every rising MOC consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst) begin
      moc_prev = 1'b0;
    end else begin
      if (moc && !moc_prev) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_pop: got MOC with empty scoreboard, required none at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("merr", 32'(merr), 32'(mon_e.merr));
          check("dataout", dout, mon_e.data);
        end
      end
      moc_prev = moc;
    end
  end

  task automatic txn(input logic r, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input int hold);
    int edges;
    @(negedge clk);
    rw = r; tdata = sz; addr = a; din = d; mov = 1'b1;
    model_access(r, sz, a, d);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (!moc) begin
        rw    = 1'($urandom);
        tdata = 2'($urandom);
        addr  = $urandom;
        din   = $urandom;
      end
    end while (!moc && edges < 40);
    check("latency", 32'(edges), 32'(WAIT + 2));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("moc_hold", 32'(moc), 32'd1);
    end
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk); #1;
    check("moc_release", 32'(moc), 32'd0);
    check("merr_release", 32'(merr), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          k;
    logic [7:0]  v;

    #1 rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      dut.mem[i] = v;
      ref_mem[i] = v;
    end
    dut.mem[4] = 8'hE3; dut.mem[5] = 8'hA0; dut.mem[6] = 8'h10; dut.mem[7] = 8'h05;
    ref_mem[4] = 8'hE3; ref_mem[5] = 8'hA0; ref_mem[6] = 8'h10; ref_mem[7] = 8'h05;
    dut0.mem[8'h10] = 8'h00;
    dut0.mem[8'h11] = 8'hC3;

    repeat (3) @(posedge clk);
    #1;
    check("rst_moc", 32'(moc), 32'd0);
    check("rst_merr", 32'(merr), 32'd0);
    check("rst_dout", dout, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Big-endian word read of the preloaded instruction.
    txn(1'b1, 2'b10, 32'd4, 32'd0, 1);
    check("word_read_value", dout, 32'hE3A01005);

    // Byte write lands in lane 23:16 of the containing word.
    txn(1'b0, 2'b00, 32'd9, 32'h1234_56AB, 1);
    txn(1'b1, 2'b10, 32'd8, 32'd0, 0);
    check("byte_lane", 32'(dout[23:16]), 32'hAB);

    // Misaligned halfword write and out-of-range read both error.
    txn(1'b0, 2'b01, 32'd3, 32'h0000_FFFF, 0);
    txn(1'b1, 2'b10, 32'h100, 32'd0, 0);
    check("oor_dout", dout, 32'd0);

    // Abort: MOV dropped during the wait states.
    @(negedge clk);
    rw = 1'b0; tdata = 2'b10; addr = 32'h20; din = 32'hDEAD_BEEF; mov = 1'b1;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    mov = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_moc", 32'(moc), 32'd0);
    end
    for (int i = 32; i < 36; i++) check("abort_mem", 32'(dut.mem[i]), 32'(ref_mem[i]));
    txn(1'b1, 2'b10, 32'h20, 32'd0, 0);

    // Reset in the middle of a write.
    txn(1'b1, 2'b10, 32'd4, 32'd0, 0);
    check("pre_reset_dout", dout, 32'hE3A01005);
    @(negedge clk);
    rw = 1'b0; tdata = 2'b10; addr = 32'h40; din = $urandom; mov = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midop_moc", 32'(moc), 32'd0);
    check("midop_dout", dout, 32'd0);
    check("midop_merr", 32'(merr), 32'd0);
    exp_dout = '0;
    @(negedge clk);
    mov = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 64; i < 68; i++) check("midop_mem", 32'(dut.mem[i]), 32'(ref_mem[i]));

    // Randomised traffic, mostly aligned and in range.
    for (int n = 0; n < 150; n++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'b11 && ($urandom % 3) != 0) sz = 2'b10;
      a = 32'($urandom_range(0, 255));
      k = $urandom_range(0, 9);
      if (k < 6) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz == 2'b10) a[1:0] = 2'b00;
      end else if (k == 9) begin
        a = a | (32'd1 << $urandom_range(8, 31));
      end
      txn(1'($urandom), sz, a, $urandom, $urandom_range(0, 2));
    end

    for (int i = 0; i < 256; i++)
      check($sformatf("mem[%0d]", i), 32'(dut.mem[i]), 32'(ref_mem[i]));

    // Zero wait states: held MOV keeps MOC up with no second access.
    @(negedge clk);
    rw0 = 1'b0; tdata0 = 2'b00; addr0 = 32'h10; din0 = 32'h1234_565A; mov0 = 1'b1;
    @(posedge clk); #1;
    check("w0_moc_capture", 32'(moc0), 32'd0);
    addr0 = 32'h11; din0 = 32'h77;
    @(posedge clk); #1;
    check("w0_moc_done", 32'(moc0), 32'd1);
    check("w0_merr", 32'(merr0), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("w0_moc_hold", 32'(moc0), 32'd1);
    end
    check("w0_mem10", 32'(dut0.mem[8'h10]), 32'h5A);
    check("w0_mem11", 32'(dut0.mem[8'h11]), 32'hC3);
    @(negedge clk);
    mov0 = 1'b0;
    @(posedge clk); #1;
    check("w0_moc_drop", 32'(moc0), 32'd0);
    @(negedge clk);
    mov0 = 1'b1; rw0 = 1'b1; tdata0 = 2'b00; addr0 = 32'h10;
    @(posedge clk); #1;
    check("w0_b2b_capture", 32'(moc0), 32'd0);
    @(posedge clk); #1;
    check("w0_b2b_moc", 32'(moc0), 32'd1);
    check("w0_b2b_dout", dout0, 32'h5A);
    @(negedge clk);
    mov0 = 1'b0;
    @(posedge clk); #1;
    check("w0_b2b_release", 32'(moc0), 32'd0);

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
